sp_ram_arbiter: RTL

SP_RAM_ARBITER -- requirements
Module: sp_ram_arbiter

---
 rtl/sp_ram_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/sp_ram_arbiter.sv
// Two-requester arbiter in front of one single-port synchronous RAM.
// Grants are combinational and complete in the grant cycle. Read data returns
// one cycle later to the requester that issued the read. A requester that sets
// lock keeps ownership for up to MAXBURST consecutive grants while the other waits.
module sp_ram_arbiter #(
  parameter int ABITS    = 4,
  parameter int WIDTH    = 8,
  parameter int MAXBURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_req,
  input  logic             r0_we,
  input  logic             r0_lock,
  input  logic [ABITS-1:0] r0_addr,
  input  logic [WIDTH-1:0] r0_wdata,
  input  logic             r1_req,
  input  logic             r1_we,
  input  logic             r1_lock,
  input  logic [ABITS-1:0] r1_addr,
  input  logic [WIDTH-1:0] r1_wdata,
  output logic             r0_gnt,
  output logic             r1_gnt,
  output logic             r0_rvalid,
  output logic             r1_rvalid,
  output logic [WIDTH-1:0] r0_rdata,
  output logic [WIDTH-1:0] r1_rdata,
  output logic             mem_wren,
  output logic             mem_rden,
  output logic [ABITS-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             busy
);

  localparam int CBITS = $clog2(MAXBURST + 1);
  localparam logic [CBITS-1:0] MAX_CNT = CBITS'(MAXBURST);

  typedef enum logic {
    OWN_R0 = 1'b0,
    OWN_R1 = 1'b1
  } owner_t;

  owner_t           last_gnt;
  owner_t           win;
  logic             prev_gnt_valid;
  logic             prev_lock;
  logic [CBITS-1:0] burst_cnt;
  logic             lock_hold;
  logic [WIDTH-1:0] rdata_hold0;
  logic [WIDTH-1:0] rdata_hold1;

  // The previous owner keeps the RAM only if it was granted in the very last
  // cycle with lock set and has not yet used up its burst allowance.
  assign lock_hold = prev_gnt_valid && prev_lock && (burst_cnt < MAX_CNT);

  // Pick at most one requester: single requester wins, conflicts go to the
  // locked owner if it still holds, otherwise to whoever was not granted last.
  always_comb begin
    r0_gnt = 1'b0;
    r1_gnt = 1'b0;
    if (!rst) begin
      if (r0_req && r1_req) begin
        if (lock_hold) begin
          if (last_gnt == OWN_R0) r0_gnt = 1'b1;
          else                    r1_gnt = 1'b1;
        end else begin
          if (last_gnt == OWN_R0) r1_gnt = 1'b1;
          else                    r0_gnt = 1'b1;
        end
      end else if (r0_req) begin
        r0_gnt = 1'b1;
      end else if (r1_req) begin
        r1_gnt = 1'b1;
      end
    end
  end

  assign win = r1_gnt ? OWN_R1 : OWN_R0;

  // Route the granted requester onto the RAM port; idle cycles drive all zeros
  // so reads and writes can never overlap.
  always_comb begin
    mem_wren  = 1'b0;
    mem_rden  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (r0_gnt) begin
      mem_wren  = r0_we;
      mem_rden  = ~r0_we;
      mem_addr  = r0_addr;
      mem_wdata = r0_wdata;
    end else if (r1_gnt) begin
      mem_wren  = r1_we;
      mem_rden  = ~r1_we;
      mem_addr  = r1_addr;
      mem_wdata = r1_wdata;
    end
  end

  // Track the last owner, its lock request and the length of its current burst;
  // an idle cycle breaks the burst so the next grant starts counting from one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt       <= OWN_R1;
      prev_gnt_valid <= 1'b0;
      prev_lock      <= 1'b0;
      burst_cnt      <= '0;
    end else if (r0_gnt || r1_gnt) begin
      last_gnt       <= win;
      prev_gnt_valid <= 1'b1;
      prev_lock      <= r1_gnt ? r1_lock : r0_lock;
      if (prev_gnt_valid && (win == last_gnt)) begin
        if (burst_cnt < MAX_CNT) burst_cnt <= burst_cnt + CBITS'(1);
      end else begin
        burst_cnt <= CBITS'(1);
      end
    end else begin
      prev_gnt_valid <= 1'b0;
      prev_lock      <= 1'b0;
      burst_cnt      <= '0;
    end
  end

  // Remember which requester issued a read so the returning data goes only to it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
    end else begin
      r0_rvalid <= r0_gnt & ~r0_we;
      r1_rvalid <= r1_gnt & ~r1_we;
    end
  end

  // Capture returned data so each requester's rdata holds once rvalid drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_hold0 <= '0;
      rdata_hold1 <= '0;
    end else begin
      if (r0_rvalid) rdata_hold0 <= mem_rdata;
      if (r1_rvalid) rdata_hold1 <= mem_rdata;
    end
  end

  // RAM output is only valid in the return cycle, so pass it straight through
  // then and fall back to the held copy afterwards.
  assign r0_rdata = r0_rvalid ? mem_rdata : rdata_hold0;
  assign r1_rdata = r1_rvalid ? mem_rdata : rdata_hold1;
  assign busy     = r0_rvalid | r1_rvalid;

endmodule
